// File: rtl/eespfal_pkg.sv
// Shared state encoding and default timing for the EESPFAL switch sequencer.
package eespfal_pkg;

  localparam int DEF_BIT_SIZE     = 4;
  localparam int DEF_SETUP_CYCLES = 2;
  localparam int DEF_EVAL_CYCLES  = 4;
  localparam int DEF_DIS_CYCLES   = 3;
  localparam int DEF_CNT_W        = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    EVAL  = 3'd2,
    HOLD  = 3'd3,
    DISCH = 3'd4
  } sw_state_e;

endpackage

// File: rtl/eespfal_sync2.sv
// Two-flop synchronizer for the macro's asynchronous s / s_bar rails.
module eespfal_sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // first flop may go metastable; second gives it a full cycle to resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/eespfal_switch_sequencer.sv
// Sequences power-clock / discharge controls and dual-rail inputs of the
// 4-bit EESPFAL switch macro, captures its result and hands it out.
module eespfal_switch_sequencer
  import eespfal_pkg::*;
#(
  parameter int BIT_SIZE     = DEF_BIT_SIZE,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int EVAL_CYCLES  = DEF_EVAL_CYCLES,
  parameter int DIS_CYCLES   = DEF_DIS_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_SIZE-1:0] x_in,
  input  logic [BIT_SIZE-1:0] k_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE-1:0] s_out,
  output logic                err,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [BIT_SIZE-1:0] sw_clk,
  output logic [BIT_SIZE-1:0] sw_dis,
  output logic                sw_dis_phase,
  output logic [BIT_SIZE-1:0] sw_x,
  output logic [BIT_SIZE-1:0] sw_x_bar,
  output logic [BIT_SIZE-1:0] sw_k,
  output logic [BIT_SIZE-1:0] sw_k_bar,
  input  logic [BIT_SIZE-1:0] sw_s,
  input  logic [BIT_SIZE-1:0] sw_s_bar
);

  sw_state_e           state;
  logic [CNT_W-1:0]    cnt;
  logic [1:0]          rst_pipe;
  logic                rst_ok;
  logic [BIT_SIZE-1:0] s_sync;
  logic [BIT_SIZE-1:0] s_bar_sync;

  eespfal_sync2 #(.W(BIT_SIZE)) u_sync_s (
    .clk(clk), .rst_n(rst_n), .d(sw_s), .q(s_sync)
  );

  eespfal_sync2 #(.W(BIT_SIZE)) u_sync_s_bar (
    .clk(clk), .rst_n(rst_n), .d(sw_s_bar), .q(s_bar_sync)
  );

  // reset asserts asynchronously but the FSM is released two edges after rst_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= '0;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_ok   = rst_pipe[1];
  assign in_ready = rst_ok && (state == IDLE);

  // sequencer FSM; every macro-facing output is updated on the state transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      sw_clk       <= '0;
      sw_dis       <= '1;
      sw_dis_phase <= 1'b1;
      sw_x         <= '0;
      sw_x_bar     <= '0;
      sw_k         <= '0;
      sw_k_bar     <= '0;
      s_out        <= '0;
      err          <= 1'b0;
      err_cnt      <= '0;
      out_valid    <= 1'b0;
    end else if (rst_ok) begin
      case (state)
        IDLE: if (in_valid) begin
          sw_x     <= x_in;
          sw_x_bar <= ~x_in;
          sw_k     <= k_in;
          sw_k_bar <= ~k_in;
          cnt      <= CNT_W'(SETUP_CYCLES - 1);
          state    <= SETUP;
        end
        SETUP: if (cnt == '0) begin
          sw_dis       <= '0;
          sw_dis_phase <= 1'b0;
          sw_clk       <= '1;
          cnt          <= CNT_W'(EVAL_CYCLES - 1);
          state        <= EVAL;
        end else cnt <= cnt - 1'b1;
        EVAL: if (cnt == '0) begin
          s_out     <= s_sync;
          err       <= |(s_sync ~^ s_bar_sync);
          out_valid <= 1'b1;
          state     <= HOLD;
        end else cnt <= cnt - 1'b1;
        HOLD: if (out_ready) begin
          if (err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
          out_valid    <= 1'b0;
          sw_clk       <= '0;
          sw_dis       <= '1;
          sw_dis_phase <= 1'b1;
          sw_x         <= '0;
          sw_x_bar     <= '0;
          sw_k         <= '0;
          sw_k_bar     <= '0;
          cnt          <= CNT_W'(DIS_CYCLES - 1);
          state        <= DISCH;
        end
        DISCH: if (cnt == '0) state <= IDLE;
               else           cnt   <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eespfal_switch_sequencer.sv
// Self-checking bench: vector table, random transactions against a
// behavioural macro/consumer model, and hand-written corner sequences.
module tb_eespfal_switch_sequencer;

  localparam int BW      = 4;
  localparam int CW      = 8;
  localparam int SETUP_C = 2;
  localparam int EVAL_C  = 4;
  localparam int DIS_C   = 3;
  // consumer sees out_valid at the (SETUP+EVAL+1)-th edge after accept
  localparam int LAT     = SETUP_C + EVAL_C + 1;
  localparam int PERIOD  = SETUP_C + EVAL_C + 1 + DIS_C + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid, err, sw_dis_phase;
  logic [BW-1:0] x_in = '0, k_in = '0;
  logic [BW-1:0] s_out, sw_clk, sw_dis, sw_x, sw_x_bar, sw_k, sw_k_bar;
  logic [BW-1:0] sw_s, sw_s_bar;
  logic [CW-1:0] err_cnt;

  int total = 0;
  int bad   = 0;
  int err_total = 0;   // error results handed out since last reset
  logic err_mode = 1'b0;

  always #5 clk = ~clk;

  eespfal_switch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .k_in(k_in), .out_valid(out_valid), .out_ready(out_ready),
    .s_out(s_out), .err(err), .err_cnt(err_cnt), .sw_clk(sw_clk),
    .sw_dis(sw_dis), .sw_dis_phase(sw_dis_phase), .sw_x(sw_x),
    .sw_x_bar(sw_x_bar), .sw_k(sw_k), .sw_k_bar(sw_k_bar),
    .sw_s(sw_s), .sw_s_bar(sw_s_bar)
  );

  // macro model: XOR switch with complementary outputs, or a broken one with both rails low
  always_comb begin
    if (err_mode) begin
      sw_s     = '0;
      sw_s_bar = '0;
    end else begin
      sw_s     = sw_x ^ sw_k;
      sw_s_bar = ~(sw_x ^ sw_k);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  // rail and control invariants every cycle
  always @(negedge clk) begin
    check("rail_x_excl", 32'((sw_x & sw_x_bar) != '0), 0);
    check("rail_k_excl", 32'((sw_k & sw_k_bar) != '0), 0);
    check("clk_dis_excl", 32'((sw_clk & sw_dis) != '0), 0);
    if (sw_clk != '0)
      check("rail_driven_eval", 32'({sw_x | sw_x_bar, sw_k | sw_k_bar}), 32'hFF);
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("ready_timeout", 32'(in_ready), 1);
  endtask

  // one full transaction; expectations come from the stimulus, not the DUT
  task automatic run_txn(input logic [BW-1:0] x, input logic [BW-1:0] k,
                         input logic mode, input int hold);
    logic [BW-1:0] exp_s;
    int n;
    exp_s = mode ? '0 : (x ^ k);
    wait_ready();
    in_valid = 1'b1; x_in = x; k_in = k; err_mode = mode; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_no_ready", 32'(in_ready), 0);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1; n++;
      if (!out_valid) check("ready_low_busy", 32'(in_ready), 0);
    end
    check("latency", 32'(n + 1), 32'(LAT));
    check("s_out", 32'(s_out), 32'(exp_s));
    check("err", 32'(err), 32'(mode));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 1);
      check("hold_s", 32'(s_out), 32'(exp_s));
      check("hold_clk", 32'(sw_clk), 32'hF);
      check("hold_dis", 32'(sw_dis), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (mode) err_total++;
    check("disch_valid", 32'(out_valid), 0);
    check("disch_clk", 32'(sw_clk), 0);
    check("disch_dis", 32'({sw_dis, 3'b000, sw_dis_phase}), 32'hF1);
    check("disch_rails", 32'({sw_x, sw_x_bar, sw_k, sw_k_bar}), 0);
    check("err_cnt", 32'(err_cnt), 32'(sat(err_total)));
  endtask

  typedef struct {
    logic [BW-1:0] x;
    logic [BW-1:0] k;
    logic          mode;
    int            hold;
  } vec_t;

  vec_t vecs[6];
  int   acc_t[$];
  int   cyc;
  logic rdy;

  initial begin
    vecs[0] = '{4'hA, 4'h3, 1'b0, 0};
    vecs[1] = '{4'h0, 4'h0, 1'b0, 0};
    vecs[2] = '{4'hF, 4'h0, 1'b0, 2};
    vecs[3] = '{4'h5, 4'hF, 1'b1, 0};
    vecs[4] = '{4'hC, 4'h6, 1'b0, 10};
    vecs[5] = '{4'h7, 4'h7, 1'b1, 10};

    // reset state
    #12;
    check("rst_ready", 32'(in_ready), 0);
    check("rst_ctrl", 32'({sw_clk, sw_dis, 3'b000, sw_dis_phase}), 32'h0F1);
    check("rst_rails", 32'({sw_x, sw_x_bar, sw_k, sw_k_bar}), 0);
    check("rst_out", 32'({s_out, 3'b000, err, err_cnt, 3'b000, out_valid}), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // table-driven vectors
    foreach (vecs[i]) run_txn(vecs[i].x, vecs[i].k, vecs[i].mode, vecs[i].hold);

    // random transactions
    for (int i = 0; i < 20; i++)
      run_txn(BW'($urandom), BW'($urandom), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3));

    // drive error results until the counter must saturate
    while (err_total < 257) run_txn(BW'($urandom), BW'($urandom), 1'b1, 0);

    // in_valid held high with out_ready tied: one accept per IDLE visit
    wait_ready();
    err_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1; x_in = 4'h6; k_in = 4'h9;
    cyc = 0;
    for (int i = 0; i < 5 * PERIOD; i++) begin
      rdy = in_ready;
      if (out_valid || sw_clk != '0) check("ready_low_active", 32'(in_ready), 0);
      @(posedge clk); cyc++;
      if (rdy) acc_t.push_back(cyc);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("cont_accepts", 32'(acc_t.size()), 5);
    for (int i = 1; i < acc_t.size(); i++)
      check("accept_spacing", 32'(acc_t[i] - acc_t[i-1]), 32'(PERIOD));
    check("cont_err_cnt", 32'(err_cnt), 32'hFF);

    // reset mid-EVAL: controls return immediately without a clock edge
    wait_ready();
    in_valid = 1'b1; x_in = 4'h3; k_in = 4'h1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_eval_clk", 32'(sw_clk), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", 32'({sw_clk, sw_dis, 3'b000, sw_dis_phase}), 32'h0F1);
    check("mid_rst_rails", 32'({sw_x, sw_x_bar, sw_k, sw_k_bar}), 0);
    check("mid_rst_errcnt", 32'(err_cnt), 0);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_ready", 32'(in_ready), 0);
    @(negedge clk); rst_n = 1'b1;
    err_total = 0;
    run_txn(4'hA, 4'h3, 1'b0, 0);
    run_txn(4'h2, 4'h4, 1'b1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
